// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings and the internal ALU operation type for alu_top.
package alu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   typedef enum logic [3:0] {
      ADD  = 4'd0,
      SUB  = 4'd1,
      AND  = 4'd2,
      OR   = 4'd3,
      XOR  = 4'd4,
      NOR  = 4'd5,
      SLT  = 4'd6,
      SLTU = 4'd7,
      NOP  = 4'd8
   } alu_op_t;

endpackage

// File: rtl/alu_control.sv
// Combinational opcode/funct decoder producing the ALU operation.
// With ALU_OVERFLOW_EN defined it also flags the trapping (signed) add/sub forms.
module alu_control
   import alu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] func_field,
`ifdef ALU_OVERFLOW_EN
   output logic       signed_arith,
`endif
   output alu_op_t    alu_op
);

   // Map opcode (and funct for R-type) onto an ALU operation; unknown encodings give NOP.
   always_comb begin
      alu_op = NOP;
      case (opcode)
         OP_RTYPE: begin
            case (func_field)
               FN_ADD, FN_ADDU: alu_op = ADD;
               FN_SUB, FN_SUBU: alu_op = SUB;
               FN_AND:          alu_op = AND;
               FN_OR:           alu_op = OR;
               FN_XOR:          alu_op = XOR;
               FN_NOR:          alu_op = NOR;
               FN_SLT:          alu_op = SLT;
               FN_SLTU:         alu_op = SLTU;
               default:         alu_op = NOP;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: alu_op = ADD;
         OP_BEQ, OP_BNE:                  alu_op = SUB;
         OP_ANDI:                         alu_op = AND;
         OP_ORI:                          alu_op = OR;
         OP_XORI:                         alu_op = XOR;
         OP_SLTI:                         alu_op = SLT;
         OP_SLTIU:                        alu_op = SLTU;
         default:                         alu_op = NOP;
      endcase
   end

`ifdef ALU_OVERFLOW_EN
   // Only add, sub and addi report signed overflow; the unsigned forms wrap silently.
   always_comb begin
      signed_arith = 1'b0;
      if (opcode == OP_RTYPE) begin
         signed_arith = (func_field == FN_ADD) || (func_field == FN_SUB);
      end else begin
         signed_arith = (opcode == OP_ADDI);
      end
   end
`endif

endmodule

// File: rtl/alu_top.sv
// Single-cycle MIPS32 execute-stage ALU with registered result and zero flag.
// Optional registered signed-overflow output when ALU_OVERFLOW_EN is defined.
module alu_top
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func_field,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] result,
`ifdef ALU_OVERFLOW_EN
   output logic             zero,
   output logic             overflow
`else
   output logic             zero
`endif
);

   alu_op_t          alu_op_s;
   logic [WIDTH-1:0] sum_s;
   logic [WIDTH-1:0] diff_s;
   logic [WIDTH-1:0] result_s;
   logic             lt_signed_s;
   logic             lt_unsigned_s;

`ifdef ALU_OVERFLOW_EN
   logic             signed_arith_s;
   logic             overflow_s;
`endif

   alu_control u_alu_control (
      .opcode       (opcode),
      .func_field   (func_field),
`ifdef ALU_OVERFLOW_EN
      .signed_arith (signed_arith_s),
`endif
      .alu_op       (alu_op_s)
   );

   assign sum_s         = A + B;
   assign diff_s        = A - B;
   assign lt_signed_s   = $signed(A) < $signed(B);
   assign lt_unsigned_s = A < B;

   // Execute mux; NOP forces a zero result so unsupported encodings are well defined.
   always_comb begin
      result_s = {WIDTH{1'b0}};
      case (alu_op_s)
         ADD:     result_s = sum_s;
         SUB:     result_s = diff_s;
         AND:     result_s = A & B;
         OR:      result_s = A | B;
         XOR:     result_s = A ^ B;
         NOR:     result_s = ~(A | B);
         SLT:     result_s = {{(WIDTH-1){1'b0}}, lt_signed_s};
         SLTU:    result_s = {{(WIDTH-1){1'b0}}, lt_unsigned_s};
         NOP:     result_s = {WIDTH{1'b0}};
         default: result_s = {WIDTH{1'b0}};
      endcase
   end

   // Output registers; zero is taken from the next result so both change on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= {WIDTH{1'b0}};
         zero   <= 1'b1;
      end else begin
         result <= result_s;
         zero   <= (result_s == {WIDTH{1'b0}});
      end
   end

`ifdef ALU_OVERFLOW_EN
   // Signed overflow: like-signed operands (B sign inverted for sub) with a differing result sign.
   always_comb begin
      overflow_s = 1'b0;
      if (signed_arith_s && (alu_op_s == ADD)) begin
         overflow_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end else if (signed_arith_s && (alu_op_s == SUB)) begin
         overflow_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end else begin
         overflow_s = 1'b0;
      end
   end

   // Overflow flag register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else begin
         overflow <= overflow_s;
      end
   end
`endif

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: scoreboard of expected results, one task per scenario.
module tb_alu_top;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        ov;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [5:0]  opcode;
   logic [5:0]  func_field;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] result;
   logic        zero;
`ifdef ALU_OVERFLOW_EN
   logic        overflow;
`endif

   int   n_cmp;
   int   n_bad;
   exp_t sb_q[$];

   alu_top #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .func_field (func_field),
      .A          (A),
      .B          (B),
      .result     (result),
`ifdef ALU_OVERFLOW_EN
      .zero       (zero),
      .overflow   (overflow)
`else
      .zero       (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model written straight from the MIPS instruction table.
   function automatic exp_t model(input logic [5:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] s;
      logic [31:0] d;
      s = a + b;
      d = a - b;
      e.res = 32'h0;
      e.ov  = 1'b0;
      if (op == 6'h00) begin
         case (fn)
            6'h20: begin e.res = s; e.ov = (a[31] == b[31]) && (s[31] != a[31]); end
            6'h21: e.res = s;
            6'h22: begin e.res = d; e.ov = (a[31] != b[31]) && (d[31] != a[31]); end
            6'h23: e.res = d;
            6'h24: e.res = a & b;
            6'h25: e.res = a | b;
            6'h26: e.res = a ^ b;
            6'h27: e.res = ~(a | b);
            6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            6'h2B: e.res = (a < b) ? 32'h1 : 32'h0;
            default: e.res = 32'h0;
         endcase
      end else begin
         case (op)
            6'h08: begin e.res = s; e.ov = (a[31] == b[31]) && (s[31] != a[31]); end
            6'h09, 6'h23, 6'h2B: e.res = s;
            6'h04, 6'h05: e.res = d;
            6'h0C: e.res = a & b;
            6'h0D: e.res = a | b;
            6'h0E: e.res = a ^ b;
            6'h0A: e.res = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
            6'h0B: e.res = (a < b) ? 32'h1 : 32'h0;
            default: e.res = 32'h0;
         endcase
      end
`ifndef ALU_OVERFLOW_EN
      e.ov = 1'b0;
`endif
      e.z = (e.res == 32'h0);
      return e;
   endfunction

   task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      opcode     = op;
      func_field = fn;
      A          = a;
      B          = b;
      sb_q.push_back(model(op, fn, a, b));
   endtask

   task automatic test_reset();
      rst = 1'b1;
      opcode = 6'h00; func_field = 6'h20; A = 32'h1234; B = 32'h1;
      #3;
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_async: result=%h zero=%b, required result=00000000 zero=1", result, zero);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_held: result=%h zero=%b, required result=00000000 zero=1", result, zero);
      end
`ifdef ALU_OVERFLOW_EN
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_overflow: overflow=%b, required 0", overflow);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Directed vectors: test-plan cases, wraparound, signed compare and unsupported encodings.
   task automatic test_directed();
      logic [5:0]  op_t[22] = '{6'h00, 6'h00, 6'h23, 6'h04, 6'h04, 6'h00, 6'h00, 6'h00,
                                6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h09, 6'h2B,
                                6'h05, 6'h0C, 6'h0D, 6'h0E, 6'h3F, 6'h00};
      logic [5:0]  fn_t[22] = '{6'h20, 6'h24, 6'h00, 6'h00, 6'h00, 6'h2A, 6'h2A, 6'h2B,
                                6'h21, 6'h23, 6'h25, 6'h26, 6'h27, 6'h22, 6'h2A, 6'h3F,
                                6'h11, 6'h20, 6'h00, 6'h00, 6'h20, 6'h00};
      logic [31:0] a_t[22]  = '{32'h2222, 32'h2222, 32'h2222, 32'h5555, 32'h5556, 32'h1111,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hF0F0,
                                32'hFF00FF00, 32'h0F0F0F0F, 32'h10, 32'hFFFFFFFE, 32'h100,
                                32'h7, 32'hABCD, 32'hA000, 32'hFFFF, 32'h1234, 32'h5678};
      logic [31:0] b_t[22]  = '{32'h1111, 32'h1111, 32'h1111, 32'h5555, 32'h5555, 32'h2222,
                                32'h1, 32'h1, 32'h2, 32'h1, 32'h0F0F, 32'hFFFF0000,
                                32'h30303030, 32'h10, 32'h2, 32'h4, 32'h7, 32'h0F0F,
                                32'h000B, 32'hFFFF, 32'h1, 32'h9};
      exp_t e;
      for (int i = 0; i < 22; i++) begin
         issue(op_t[i], fn_t[i], a_t[i], b_t[i]);
         @(posedge clk); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (result !== e.res || zero !== e.z) begin
            n_bad++;
            $display("FAIL directed_%0d: result=%h zero=%b, required result=%h zero=%b",
                     i, result, zero, e.res, e.z);
         end
      end
      // Explicit test-plan constants, independent of the model.
      issue(6'h00, 6'h2A, 32'hFFFFFFFF, 32'h1);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (result !== 32'h1 || zero !== 1'b0) begin
         n_bad++;
         $display("FAIL slt_neg_const: result=%h zero=%b, required result=00000001 zero=0", result, zero);
      end
      issue(6'h00, 6'h2B, 32'hFFFFFFFF, 32'h1);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         n_bad++;
         $display("FAIL sltu_neg_const: result=%h zero=%b, required result=00000000 zero=1", result, zero);
      end
   endtask

   // Random mix issued every cycle with no idle gaps.
   task automatic test_back_to_back();
      logic [5:0] op_t[8] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h04, 6'h2B};
      logic [5:0] fn_t[11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h08};
      exp_t e;
      for (int i = 0; i < 60; i++) begin
         issue(op_t[$urandom_range(0, 7)], fn_t[$urandom_range(0, 10)],
               (i % 7 == 0) ? 32'h80000000 : $urandom,
               (i % 5 == 0) ? A : $urandom);
         @(posedge clk); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (result !== e.res || zero !== e.z) begin
            n_bad++;
            $display("FAIL b2b_%0d: op=%h fn=%h result=%h zero=%b, required result=%h zero=%b",
                     i, opcode, func_field, result, zero, e.res, e.z);
         end
`ifdef ALU_OVERFLOW_EN
         n_cmp++;
         if (overflow !== e.ov) begin
            n_bad++;
            $display("FAIL b2b_ovf_%0d: overflow=%b, required %b", i, overflow, e.ov);
         end
`endif
      end
   endtask

   task automatic test_async_reset();
      exp_t e;
      issue(6'h00, 6'h20, 32'h2222, 32'h1111);
      @(posedge clk); #1;
      e = sb_q.pop_front();
      n_cmp++;
      if (result !== e.res || zero !== e.z) begin
         n_bad++;
         $display("FAIL pre_reset: result=%h zero=%b, required result=%h zero=%b", result, zero, e.res, e.z);
      end
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if (result !== 32'h0 || zero !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_reset: result=%h zero=%b, required result=00000000 zero=1", result, zero);
      end
      @(negedge clk);
      rst = 1'b0;
      opcode = 6'h0D; func_field = 6'h00; A = 32'hA0; B = 32'h05;
      @(posedge clk); #1;
      n_cmp++;
      if (result !== 32'hA5 || zero !== 1'b0) begin
         n_bad++;
         $display("FAIL post_reset_load: result=%h zero=%b, required result=000000a5 zero=0", result, zero);
      end
   endtask

`ifdef ALU_OVERFLOW_EN
   task automatic test_overflow();
      logic [5:0]  op_t[6] = '{6'h00, 6'h00, 6'h08, 6'h00, 6'h00, 6'h09};
      logic [5:0]  fn_t[6] = '{6'h20, 6'h21, 6'h00, 6'h22, 6'h23, 6'h00};
      logic [31:0] a_t[6]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000000,
                               32'h80000000, 32'h7FFFFFFF};
      logic [31:0] b_t[6]  = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h1};
      logic        ov_t[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         issue(op_t[i], fn_t[i], a_t[i], b_t[i]);
         @(posedge clk); #1;
         e = sb_q.pop_front();
         n_cmp++;
         if (result !== e.res || overflow !== ov_t[i]) begin
            n_bad++;
            $display("FAIL overflow_%0d: result=%h overflow=%b, required result=%h overflow=%b",
                     i, result, overflow, e.res, ov_t[i]);
         end
      end
   endtask
`endif

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_directed();
      test_back_to_back();
      test_async_reset();
`ifdef ALU_OVERFLOW_EN
      test_overflow();
`endif
      n_cmp++;
      if (sb_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- Single-cycle MIPS32 ALU block: decodes the instruction opcode/funct into an ALU operation and executes it on two 32-bit operands.
- Produces a 32-bit result and a zero flag.
- Sits in the execute stage; the datapath supplies A (rs value) and B (rt value or an already-extended immediate).
- Outputs are registered on the single clock.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is required to be supported).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  6  instruction bits [31:26]
- func_field  input  6  instruction bits [5:0]; only meaningful when opcode==0
- A  input  32  first operand
- B  input  32  second operand; immediates arrive already sign/zero-extended
- result  output  32  registered ALU result
- zero  output  1  registered flag, 1 when the registered result == 0

Behaviour:
- Reset: while rst=1, result=0 and zero=1, asynchronously. Zero is consistent with result==0.
- Latency: inputs sampled at a rising clk edge appear on result/zero after that same edge (1 cycle). No handshake; a new operation every cycle.
- Operation decode is combinational (alu_control).
- R-type, opcode 0x00:
  - func 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu
  - 0x24 and, 0x25 or, 0x26 xor, 0x27 nor
  - 0x2A slt (signed), 0x2B sltu (unsigned)
- I-type:
  - 0x08 addi / 0x09 addiu -> add
  - 0x23 lw / 0x2B sw -> add (address generation)
  - 0x04 beq / 0x05 bne -> sub (zero drives the branch decision)
  - 0x0C andi -> and; 0x0D ori -> or; 0x0E xori -> xor
  - 0x0A slti -> signed slt; 0x0B sltiu -> unsigned slt
- For I-type opcodes, func_field is ignored.
- Arithmetic rules:
  - add/sub are modulo 2^32 and wrap silently (no trap).
  - slt result is 32'h1 or 32'h0.
  - Signed compare uses two's-complement: e.g. 0xFFFFFFFF < 0x00000001 for slt, but not for sltu.
- Unsupported opcode/funct combination: result=0, zero=1 (defined, never X).
- zero is computed from the next result value, so it updates on the same edge as result.
- Reset asserted mid-operation clears the outputs immediately. The first edge after rst falls loads the current inputs.

Optional Feature:
- Macro ALU_OVERFLOW_EN.
- When defined:
  - Adds output port `overflow` (1 bit), registered and reset to 0.
  - Set to 1 for signed add/addi/sub when a signed overflow occurs (operand signs agree and the result sign differs; for sub, the B sign is taken as inverted).
  - 0 for all other operations, including addu/subu/addiu.
- When undefined: no overflow port and no overflow logic; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI)
  - funct constants (FN_ADD … FN_SLTU)
  - an enumerated alu_op_t (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, NOP)
- One sub-module, alu_control: combinational opcode/func_field -> alu_op_t decoder.
- The execute mux and output registers live in alu_top.

Test Plan:
- A=0x2222, B=0x1111, opcode=0x00, func=0x20 -> after next edge result=0x00003333, zero=0.
- Same operands, func=0x24 (and) -> result=0x00000000, zero=1.
- Same operands, opcode=0x23 (lw, func 0) -> result=0x00003333, zero=0.
- A=B=0x5555, opcode=0x04 (beq) -> result=0, zero=1; with A=0x5556 -> result=1, zero=0.
- A=0x1111, B=0x2222, opcode=0x00, func=0x2A -> result=1. With A=0xFFFFFFFF, B=1: slt -> 1, sltu (0x2B) -> 0.
- Assert rst between clock edges while result is nonzero -> result=0, zero=1 immediately. With ALU_OVERFLOW_EN, add of 0x7FFFFFFF+1 -> result=0x80000000, overflow=1; addu of the same operands -> overflow=0.
